// File: rtl/usb_audio_pkg.sv
// ---------------------------------------------------------------------------
// usb_audio_pkg
// Shared definitions for the USB audio datapath blocks.
//   GAIN_WIDTH / GAIN_UNITY : channel gain format (9-bit unsigned, 256 = 1.0)
//   PCM_WIDTH               : default signed PCM sample width
//   stereo_frame_t          : one left/right signed sample pair
//   volumeToGain()          : maps an 8-bit control-endpoint volume to a gain
// ---------------------------------------------------------------------------
package usb_audio_pkg;

    localparam int GAIN_WIDTH = 9;
    localparam int GAIN_UNITY = 256;
    localparam int PCM_WIDTH  = 24;

    typedef struct packed {
        logic signed [PCM_WIDTH-1:0] left;
        logic signed [PCM_WIDTH-1:0] right;
    } stereo_frame_t;

    // Adding the volume MSB back in stretches 0x00..0xFF onto 0..256, so full
    // volume is exact unity while the mapping stays monotonic.
    function automatic logic [GAIN_WIDTH-1:0] volumeToGain(input logic [7:0] volume);
        return {1'b0, volume} + {{(GAIN_WIDTH-1){1'b0}}, volume[7]};
    endfunction

endpackage

// File: rtl/usb_gain_ramp.sv
// ---------------------------------------------------------------------------
// usb_gain_ramp
// Per-channel gain register that walks toward a target gain by a fixed step
// each time a frame is accepted, clamping at the target.
//   clk_i       : system clock
//   reset_ni    : synchronous, active-low reset (gain -> 0)
//   target_i    : gain the channel should settle at (0..256)
//   stepEn_i    : one step is taken in a cycle where this is high
//   forceZero_i : drops the gain straight to 0 on the next clock
//   gain_o      : current gain
// ---------------------------------------------------------------------------
module usb_gain_ramp
    import usb_audio_pkg::*;
#(
    parameter int RAMP_STEP = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [GAIN_WIDTH-1:0] target_i,
    input  logic                  stepEn_i,
    input  logic                  forceZero_i,
    output logic [GAIN_WIDTH-1:0] gain_o
);

    // A step larger than unity would only ever jump straight to the target.
    localparam logic [GAIN_WIDTH-1:0] STEP = (RAMP_STEP > GAIN_UNITY)
        ? GAIN_WIDTH'(GAIN_UNITY) : GAIN_WIDTH'(RAMP_STEP);

    logic [GAIN_WIDTH-1:0] gain_q;
    logic [GAIN_WIDTH-1:0] gain_d;

    // Move toward the target by STEP, landing exactly on it when closer than
    // one step; the subtractions are ordered so neither can underflow.
    always_comb begin
        gain_d = gain_q;
        if (forceZero_i) begin
            gain_d = '0;
        end else if (stepEn_i) begin
            if (gain_q < target_i) begin
                gain_d = ((target_i - gain_q) > STEP) ? (gain_q + STEP) : target_i;
            end else if (gain_q > target_i) begin
                gain_d = ((gain_q - target_i) > STEP) ? (gain_q - STEP) : target_i;
            end
        end
    end

    // Gain register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            gain_q <= '0;
        end else begin
            gain_q <= gain_d;
        end
    end

    assign gain_o = gain_q;

endmodule

// File: rtl/usb_volume_ramp.sv
// ---------------------------------------------------------------------------
// usb_volume_ramp
// Applies the control endpoint's Active/Mute/Volume settings to the stereo
// PCM stream, ramping each channel's gain one step per accepted frame to
// avoid zipper noise and clicks.
//   Clk, Reset                 : clock, synchronous active-low reset
//   Active, Mute               : interface active / mute controls
//   Volume_Left, Volume_Right  : 8-bit volumes (0x00 silent, 0xFF unity)
//   In_Valid/In_Ready/In_*     : incoming signed stereo frames
//   Out_Valid/Out_Ready/Out_*  : scaled stereo frames, 2-stage pipeline
//   Silent                     : both gains 0 and pipeline empty (registered)
// ---------------------------------------------------------------------------
module usb_volume_ramp
    import usb_audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 24,
    parameter int RAMP_STEP    = 1
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           Active,
    input  logic                           Mute,
    input  logic [7:0]                     Volume_Left,
    input  logic [7:0]                     Volume_Right,
    input  logic                           In_Valid,
    output logic                           In_Ready,
    input  logic signed [SAMPLE_WIDTH-1:0] In_Left,
    input  logic signed [SAMPLE_WIDTH-1:0] In_Right,
    output logic                           Out_Valid,
    input  logic                           Out_Ready,
    output logic signed [SAMPLE_WIDTH-1:0] Out_Left,
    output logic signed [SAMPLE_WIDTH-1:0] Out_Right,
    output logic                           Silent
);

    localparam int PW = SAMPLE_WIDTH + 10;

    logic                         en;
    logic                         accept;
    logic                         zeroTarget;
    logic                         forceZero;
    logic [GAIN_WIDTH-1:0]        targetLeft;
    logic [GAIN_WIDTH-1:0]        targetRight;
    logic [GAIN_WIDTH-1:0]        gainLeft;
    logic [GAIN_WIDTH-1:0]        gainRight;

    logic                         s1Valid_q,     s1Valid_d;
    logic signed [SAMPLE_WIDTH-1:0] s1Left_q,    s1Left_d;
    logic signed [SAMPLE_WIDTH-1:0] s1Right_q,   s1Right_d;
    logic [GAIN_WIDTH-1:0]        s1GainLeft_q,  s1GainLeft_d;
    logic [GAIN_WIDTH-1:0]        s1GainRight_q, s1GainRight_d;
    logic                         outValid_q,    outValid_d;
    logic signed [SAMPLE_WIDTH-1:0] outLeft_q,   outLeft_d;
    logic signed [SAMPLE_WIDTH-1:0] outRight_q,  outRight_d;
    logic                         silent_q,      silent_d;

    logic signed [PW-1:0]         productLeft;
    logic signed [PW-1:0]         productRight;
    logic signed [SAMPLE_WIDTH-1:0] scaledLeft;
    logic signed [SAMPLE_WIDTH-1:0] scaledRight;
    logic                         unusedProductBits;

    // The whole pipeline moves as one unit; In_Ready is combinational from
    // Out_Ready so a full pipeline can still stream one frame per clock.
    assign en       = Out_Ready | ~outValid_q;
    assign In_Ready = en;
    assign accept   = In_Valid & en;

    assign zeroTarget  = Mute | ~Active;
    assign forceZero   = ~Active;
    assign targetLeft  = zeroTarget ? '0 : volumeToGain(Volume_Left);
    assign targetRight = zeroTarget ? '0 : volumeToGain(Volume_Right);

    usb_gain_ramp #(.RAMP_STEP(RAMP_STEP)) u_rampLeft (
        .clk_i       (Clk),
        .reset_ni    (Reset),
        .target_i    (targetLeft),
        .stepEn_i    (accept),
        .forceZero_i (forceZero),
        .gain_o      (gainLeft)
    );

    usb_gain_ramp #(.RAMP_STEP(RAMP_STEP)) u_rampRight (
        .clk_i       (Clk),
        .reset_ni    (Reset),
        .target_i    (targetRight),
        .stepEn_i    (accept),
        .forceZero_i (forceZero),
        .gain_o      (gainRight)
    );

    // Both operands are widened to the product width; the gain is zero-
    // extended so 256 stays positive. Taking bits above 8 is an arithmetic
    // shift, i.e. truncation toward minus infinity.
    assign productLeft  = $signed({{10{s1Left_q[SAMPLE_WIDTH-1]}}, s1Left_q})
                        * $signed({{(SAMPLE_WIDTH+1){1'b0}}, s1GainLeft_q});
    assign productRight = $signed({{10{s1Right_q[SAMPLE_WIDTH-1]}}, s1Right_q})
                        * $signed({{(SAMPLE_WIDTH+1){1'b0}}, s1GainRight_q});
    assign scaledLeft   = productLeft[SAMPLE_WIDTH+7:8];
    assign scaledRight  = productRight[SAMPLE_WIDTH+7:8];

    // Gain never exceeds unity, so the dropped top bits are pure sign copies.
    assign unusedProductBits = ^{productLeft[PW-1:SAMPLE_WIDTH+8], productLeft[7:0],
                                 productRight[PW-1:SAMPLE_WIDTH+8], productRight[7:0]};

    // Next-state for both pipeline stages: stage 1 captures the frame with
    // the gains in force before this cycle's ramp step, stage 2 captures the
    // scaled result. Nothing moves while the output is stalled.
    always_comb begin
        s1Valid_d     = s1Valid_q;
        s1Left_d      = s1Left_q;
        s1Right_d     = s1Right_q;
        s1GainLeft_d  = s1GainLeft_q;
        s1GainRight_d = s1GainRight_q;
        outValid_d    = outValid_q;
        outLeft_d     = outLeft_q;
        outRight_d    = outRight_q;
        if (en) begin
            s1Valid_d = accept;
            if (accept) begin
                s1Left_d      = In_Left;
                s1Right_d     = In_Right;
                s1GainLeft_d  = gainLeft;
                s1GainRight_d = gainRight;
            end
            outValid_d = s1Valid_q;
            if (s1Valid_q) begin
                outLeft_d  = scaledLeft;
                outRight_d = scaledRight;
            end
        end
        silent_d = (gainLeft == '0) && (gainRight == '0) && !s1Valid_q && !outValid_q;
    end

    // Pipeline and status registers; reset drops any frames in flight.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            s1Valid_q     <= 1'b0;
            s1Left_q      <= '0;
            s1Right_q     <= '0;
            s1GainLeft_q  <= '0;
            s1GainRight_q <= '0;
            outValid_q    <= 1'b0;
            outLeft_q     <= '0;
            outRight_q    <= '0;
            silent_q      <= 1'b1;
        end else begin
            s1Valid_q     <= s1Valid_d;
            s1Left_q      <= s1Left_d;
            s1Right_q     <= s1Right_d;
            s1GainLeft_q  <= s1GainLeft_d;
            s1GainRight_q <= s1GainRight_d;
            outValid_q    <= outValid_d;
            outLeft_q     <= outLeft_d;
            outRight_q    <= outRight_d;
            silent_q      <= silent_d;
        end
    end

    assign Out_Valid = outValid_q;
    assign Out_Left  = outLeft_q;
    assign Out_Right = outRight_q;
    assign Silent    = silent_q;

endmodule

// File: doc/usb_volume_ramp.md
Name: usb_volume_ramp

Overview:
- Downstream consumer of the USB control endpoint's Active, Mute and per-channel Volume outputs.
- Applies those settings to the stereo PCM stream from the isochronous OUT endpoint before it reaches the DAC path.
- Ramps each channel's gain one step per stereo frame toward its target. This removes zipper noise and clicks on volume, mute and activation changes.
- Valid/ready stream in and out; 2-stage pipeline.

Parameters:
- SAMPLE_WIDTH, 24: signed PCM sample width per channel.
- RAMP_STEP, 1: gain change per accepted frame, in gain LSBs (1..256).

Ports:
- Clk  input  1  system clock.
- Reset  input  1  synchronous, active-low reset.
- Active  input  1  audio interface alternate setting active.
- Mute  input  1  mute control.
- Volume_Left  input  8  left volume, 0x00 = silent, 0xFF = full.
- Volume_Right  input  8  right volume.
- In_Valid  input  1  stereo frame present.
- In_Ready  output  1  frame accepted when In_Valid & In_Ready.
- In_Left  input  SAMPLE_WIDTH  left sample, signed.
- In_Right  input  SAMPLE_WIDTH  right sample, signed.
- Out_Valid  output  1  scaled frame present.
- Out_Ready  input  1  downstream accepts.
- Out_Left  output  SAMPLE_WIDTH  scaled left sample.
- Out_Right  output  SAMPLE_WIDTH  scaled right sample.
- Silent  output  1  both gains 0 and pipeline empty.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low. While Reset = 0:
  - Gain_L = Gain_R = 0.
  - Both stage valid bits = 0; Out_Valid = 0.
  - Out_Left = Out_Right = 0.
  - Silent = 1.
  - In_Ready follows the stall rule below.
- Reset asserted mid-operation discards in-flight frames with no output.
- Gain registers: 9-bit unsigned, range 0..256; 256 = unity.
- Target per channel = (Mute | ~Active) ? 0 : Volume + Volume[7].
  - Maps 0x00→0, 0x7F→127, 0x80→129, 0xFF→256.
  - The mapping is monotonic and reaches exact unity.
- Ramp: on each accepted frame, each gain independently:
  - moves toward its target by RAMP_STEP;
  - clamps at the target (never overshoots);
  - holds if already equal to the target.
- The frame is scaled with the gain value from before that update.
- Active = 0 forces both gains to 0 on the next clock, regardless of stream traffic. The stream is stopped in this mode, so a ramp could never complete.
- Volume/Mute changes with no frames flowing change only the target; gains do not move.
- Arithmetic: product = sample × {0,gain}, signed, SAMPLE_WIDTH+10 bits.
  - Output = product >>> 8, truncated toward −inf, bits [SAMPLE_WIDTH-1:0].
  - Gain ≤ 256, so the result never overflows; −2^(W−1) at unity stays −2^(W−1).
- Pipeline:
  - Stage 1 registers the samples and the applied gains.
  - Stage 2 registers the scaled result onto Out_*.
  - Global enable En = Out_Ready | ~Out_Valid. All stages advance only when En = 1.
  - In_Ready = En (combinational from Out_Ready; documented path).
  - Latency is 2 clocks from acceptance to Out_Valid with Out_Ready held high.
  - Throughput is 1 frame/clock.
- Backpressure: while Out_Valid & ~Out_Ready:
  - Out_* hold stable;
  - no frame is accepted;
  - gains do not update.
- Simultaneous target change and accepted frame: the frame uses the old gain, and the ramp steps toward the new target in that cycle.
- Silent = (Gain_L == 0) & (Gain_R == 0) & no valid in either stage. Registered; 1-cycle delay permitted.

Decomposition:
- Shared package usb_audio_pkg holds:
  - GAIN_WIDTH = 9, GAIN_UNITY = 256;
  - the stereo frame struct typedef (left/right signed samples);
  - the target-mapping function (Volume → gain).
- One natural sub-module: usb_gain_ramp, a per-channel ramp register (target, step enable, RAMP_STEP, force-zero → gain). Instantiated twice.
- The multiply/pipeline stays in the top module.

Test Plan:
- Reset release, Volume_L = Volume_R = 0xFF, Active = 1, Mute = 0; feed 300 frames of +0x100000 with Out_Ready = 1 → frame n outputs (0x100000·min(n,256))>>8. Frame 0 outputs 0; frames ≥256 output exactly 0x100000. Latency 2 clocks; Silent 1→0.
- Volume 0x80 settled (gain 129); In_Left = 256, In_Right = −3 → Out_Left = 129, Out_Right = −2 (0xFFFFFE, floor of −1.51).
- At unity: Mute 0→1 → gain falls 256→0 over exactly 256 frames with no step >1; then Silent = 1 once the pipeline drains. Mute 1→0 ramps back up symmetrically.
- Random In_Valid/Out_Ready toggling (50% each), 1000 frames → output frames equal the reference model in order; no drops or duplicates; Out_* stable throughout every stall.
- Active 1→0 mid-ramp with no In_Valid → both gains 0 on the next clock; Silent asserts once the pipeline is empty.
- Reset pulsed low for 1 clock with both stages full → Out_Valid = 0 next clock; pre-reset frames are never emitted; gains = 0.
